fb_source_scheduler: RTL

Frame-safe source-selection controller for the framebuffer input mux. It takes the HPS mode request (source select, tone-mapping enable, parallax correction) and tracks frame boundaries on the cam0, cam1 and HDR streams. It commits a new selection only when both the outgoing and incoming sources are between frames, so no torn frame reaches the framebuffer. A watchdog falls back to cam0 when the selected source stops producing frames.

---
 rtl/fb_source_scheduler_pkg.sv | 49 ++++
 rtl/fb_source_scheduler_if.sv | 41 ++++
 rtl/fb_source_scheduler_frame_tracker.sv | 38 +++
 rtl/fb_source_scheduler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fb_source_scheduler_pkg.sv
// fb_sched_pkg: shared types and helpers for the framebuffer source scheduler.
//   src_t       : committed source encoding (cam0, cam1, hdr)
//   state_t     : scheduler FSM states (between frames / mid frame)
//   hps_req_t   : decoded HPS mode request
//   PARALLAX_RST: reset value of the committed parallax correction
package fb_sched_pkg;

  typedef enum logic [1:0] {
    SRC_CAM0 = 2'd0,
    SRC_CAM1 = 2'd1,
    SRC_HDR  = 2'd2
  } src_t;

  typedef enum logic {
    S_GAP   = 1'b0,
    S_FRAME = 1'b1
  } state_t;

  typedef struct packed {
    src_t src;
    logic tm;
  } hps_req_t;

  localparam logic [7:0] PARALLAX_RST = 8'd10;

  // Decode the HPS switch word; code 00 falls back to cam0, bit 3 is unused.
  function automatic hps_req_t decode_hps_switch(input logic [3:0] sw);
    hps_req_t r;
    case (sw[1:0])
      2'b10:   r.src = SRC_CAM1;
      2'b11:   r.src = SRC_HDR;
      default: r.src = SRC_CAM0;
    endcase
    r.tm = sw[2];
    return r;
  endfunction

  // Select the per-source bit {hdr, cam1, cam0} belonging to a source code.
  function automatic logic pick_src(input logic [2:0] bits, input src_t s);
    logic b;
    case (s)
      SRC_CAM1: b = bits[1];
      SRC_HDR:  b = bits[2];
      default:  b = bits[0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fb_source_scheduler_if.sv
// fb_source_scheduler_if: groups the HPS request, the three stream framing
// buses and the committed-configuration outputs of the scheduler.
//   master : request/stream driver side (HPS + camera pipelines)
//   slave  : scheduler side
interface fb_source_scheduler_if;
  logic [3:0] hps_switch;
  logic [7:0] parallax_corr;
  logic       data_valid_cam_0;
  logic       sop_cam_0;
  logic       eop_cam_0;
  logic       data_valid_cam_1;
  logic       sop_cam_1;
  logic       eop_cam_1;
  logic       data_valid_hdr;
  logic       sop_hdr;
  logic       eop_hdr;
  logic [1:0] src_sel;
  logic       enable_tone_mapping;
  logic [7:0] reg_parallax_corr;
  logic       switch_done;
  logic       pending;
  logic       timeout_flag;

  modport master (
    output hps_switch, parallax_corr,
    output data_valid_cam_0, sop_cam_0, eop_cam_0,
    output data_valid_cam_1, sop_cam_1, eop_cam_1,
    output data_valid_hdr, sop_hdr, eop_hdr,
    input  src_sel, enable_tone_mapping, reg_parallax_corr,
    input  switch_done, pending, timeout_flag
  );

  modport slave (
    input  hps_switch, parallax_corr,
    input  data_valid_cam_0, sop_cam_0, eop_cam_0,
    input  data_valid_cam_1, sop_cam_1, eop_cam_1,
    input  data_valid_hdr, sop_hdr, eop_hdr,
    output src_sel, enable_tone_mapping, reg_parallax_corr,
    output switch_done, pending, timeout_flag
  );
endinterface

// File: rtl/fb_source_scheduler_frame_tracker.sv
// fb_frame_tracker: tracks whether one stream is currently inside a frame.
//   clk, reset : pixel clock, synchronous active-high reset
//   valid      : beat qualifier
//   sop, eop   : start / end of frame markers
//   in_frame   : registered, high between an accepted SOP and its EOP
module fb_frame_tracker (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  logic sop,
  input  logic eop,
  output logic in_frame
);

  logic in_frame_nxt_s;

  // Next flag value; EOP has priority so a single-beat frame ends idle.
  always_comb begin
    in_frame_nxt_s = in_frame;
    if (valid && eop) begin
      in_frame_nxt_s = 1'b0;
    end else if (valid && sop) begin
      in_frame_nxt_s = 1'b1;
    end else begin
      in_frame_nxt_s = in_frame;
    end
  end

  // Frame flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_frame <= 1'b0;
    end else begin
      in_frame <= in_frame_nxt_s;
    end
  end

endmodule

// File: rtl/fb_source_scheduler.sv
// fb_source_scheduler: frame-safe source selection for the framebuffer mux.
// A new request is committed only while the active source is between frames
// and the requested source is idle; a watchdog falls back to cam0 when the
// active source stops delivering SOPs.
//   clk, reset : pixel clock, synchronous active-high reset
//   sif        : slave side of fb_source_scheduler_if
//                (request + stream framing in, committed config out)
// Parameters:
//   TIMEOUT_CYC  : cycles without an active SOP or commit before fallback
//   PARALLAX_RST : reset value of reg_parallax_corr
module fb_source_scheduler #(
  parameter int unsigned TIMEOUT_CYC  = 2**24,
  parameter logic [7:0]  PARALLAX_RST = fb_sched_pkg::PARALLAX_RST
) (
  input  logic                  clk,
  input  logic                  reset,
  fb_source_scheduler_if.slave  sif
);

  import fb_sched_pkg::*;

  localparam int CNT_W = (TIMEOUT_CYC > 32'd2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_nxt_s;
  src_t             src_sel_r;
  logic             tm_r;
  logic [7:0]       par_r;
  logic             switch_done_r;
  logic             pending_r;
  logic             timeout_flag_r;
  logic [CNT_W-1:0] wd_cnt_r;

  logic [2:0]       valid_s;
  logic [2:0]       sop_s;
  logic [2:0]       eop_s;
  logic [2:0]       in_frame_s;
  hps_req_t         req_s;
  logic             pending_s;
  logic             act_sop_s;
  logic             act_eop_s;
  logic             tgt_busy_s;
  logic             timeout_s;
  logic             commit_s;
  src_t             src_nxt_s;
  logic             tm_nxt_s;
  logic [7:0]       par_nxt_s;
  logic             tf_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  assign valid_s = {sif.data_valid_hdr, sif.data_valid_cam_1, sif.data_valid_cam_0};
  assign sop_s   = {sif.sop_hdr,        sif.sop_cam_1,        sif.sop_cam_0};
  assign eop_s   = {sif.eop_hdr,        sif.eop_cam_1,        sif.eop_cam_0};

  fb_frame_tracker u_trk_cam0 (
    .clk(clk), .reset(reset),
    .valid(valid_s[0]), .sop(sop_s[0]), .eop(eop_s[0]),
    .in_frame(in_frame_s[0])
  );

  fb_frame_tracker u_trk_cam1 (
    .clk(clk), .reset(reset),
    .valid(valid_s[1]), .sop(sop_s[1]), .eop(eop_s[1]),
    .in_frame(in_frame_s[1])
  );

  fb_frame_tracker u_trk_hdr (
    .clk(clk), .reset(reset),
    .valid(valid_s[2]), .sop(sop_s[2]), .eop(eop_s[2]),
    .in_frame(in_frame_s[2])
  );

  // Request decode, active-source framing and commit blockers.
  always_comb begin
    req_s      = decode_hps_switch(sif.hps_switch);
    pending_s  = (req_s.src != src_sel_r) || (req_s.tm != tm_r) ||
                 (sif.parallax_corr != par_r);
    act_sop_s  = pick_src(valid_s & sop_s, src_sel_r);
    act_eop_s  = pick_src(valid_s & eop_s, src_sel_r);
    tgt_busy_s = pick_src(in_frame_s, req_s.src);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_GAP;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; a single-beat frame on the active source leaves it between frames.
  always_comb begin
    state_nxt_s = state_r;
    if (timeout_s) begin
      state_nxt_s = S_GAP;
    end else begin
      case (state_r)
        S_GAP: begin
          if (act_sop_s && !act_eop_s) begin
            state_nxt_s = S_FRAME;
          end else begin
            state_nxt_s = S_GAP;
          end
        end
        S_FRAME: begin
          if (act_eop_s) begin
            state_nxt_s = S_GAP;
          end else begin
            state_nxt_s = S_FRAME;
          end
        end
        default: state_nxt_s = S_GAP;
      endcase
    end
  end

  // FSM outputs: watchdog beats commit, and an active SOP blocks a commit.
  always_comb begin
    timeout_s = (wd_cnt_r == CNT_LAST);
    if (!timeout_s && (state_r == S_GAP) && !act_sop_s && pending_s && !tgt_busy_s) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end

    src_nxt_s = src_sel_r;
    tm_nxt_s  = tm_r;
    par_nxt_s = par_r;
    tf_nxt_s  = timeout_flag_r;
    cnt_nxt_s = wd_cnt_r;
    if (timeout_s) begin
      src_nxt_s = SRC_CAM0;
      tf_nxt_s  = 1'b1;
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (commit_s) begin
      src_nxt_s = req_s.src;
      tm_nxt_s  = req_s.tm;
      par_nxt_s = sif.parallax_corr;
      tf_nxt_s  = 1'b0;
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (act_sop_s) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (wd_cnt_r != CNT_MAX) begin
      cnt_nxt_s = wd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = wd_cnt_r;
    end
  end

  // Committed configuration, status flags and watchdog counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_sel_r      <= SRC_CAM0;
      tm_r           <= 1'b0;
      par_r          <= PARALLAX_RST;
      switch_done_r  <= 1'b0;
      pending_r      <= 1'b0;
      timeout_flag_r <= 1'b0;
      wd_cnt_r       <= {CNT_W{1'b0}};
    end else begin
      src_sel_r      <= src_nxt_s;
      tm_r           <= tm_nxt_s;
      par_r          <= par_nxt_s;
      switch_done_r  <= commit_s;
      // Compared against the post-edge configuration so it matches the outputs.
      pending_r      <= (req_s.src != src_nxt_s) || (req_s.tm != tm_nxt_s) ||
                        (sif.parallax_corr != par_nxt_s);
      timeout_flag_r <= tf_nxt_s;
      wd_cnt_r       <= cnt_nxt_s;
    end
  end

  assign sif.src_sel             = src_sel_r;
  assign sif.enable_tone_mapping = tm_r;
  assign sif.reg_parallax_corr   = par_r;
  assign sif.switch_done         = switch_done_r;
  assign sif.pending             = pending_r;
  assign sif.timeout_flag        = timeout_flag_r;

endmodule
